// File: rtl/cpu_pkg.sv
// Shared CPU back-end definitions used by the CDB arbiter and its result FIFOs.
//   NUM_FU / PREG_W / XLEN : default machine widths
//   cdb_pkt_t              : one broadcast payload {tag, data}
//   fu_id_e                : functional-unit index encoding
package cpu_pkg;

    localparam int unsigned NUM_FU = 3;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned XLEN   = 32;

    typedef struct packed {
        logic [PREG_W-1:0] tag;
        logic [XLEN-1:0]   data;
    } cdb_pkt_t;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2
    } fu_id_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of the functional-unit result handshake and the common data bus.
//   fu_valid/fu_tag/fu_data : per-FU results (FU i at slice i)
//   fu_ready                : per-FU acceptance
//   cdb_valid/tag/data/fu_id: registered broadcast
// Modports: master = FU + consumer side, slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU = cpu_pkg::NUM_FU,
    parameter int unsigned PREG_W = cpu_pkg::PREG_W,
    parameter int unsigned XLEN   = cpu_pkg::XLEN
);

    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*PREG_W-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]   fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [PREG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]          cdb_data;
    logic [1:0]               cdb_fu_id;

    modport master (
        output fu_valid,
        output fu_tag,
        output fu_data,
        input  fu_ready,
        input  cdb_valid,
        input  cdb_tag,
        input  cdb_data,
        input  cdb_fu_id
    );

    modport slave (
        input  fu_valid,
        input  fu_tag,
        input  fu_data,
        output fu_ready,
        output cdb_valid,
        output cdb_tag,
        output cdb_data,
        output cdb_fu_id
    );

endinterface

// File: rtl/cdb_fifo.sv
// Small result FIFO holding cdb_pkt_t entries for one functional unit.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of all entries (wins over push/pop)
//   push       : write push_pkt at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (undefined when empty)
//   full/empty : registered occupancy flags
module cdb_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  cdb_pkt_t push_pkt,
    output cdb_pkt_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    cdb_pkt_t        mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so increment wraps on its own.
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_pkt;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers each FU's results in a cdb_fifo and broadcasts at
// most one per cycle, round-robin, on a registered CDB.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop all buffered results and any push this cycle; no grant
//   bus        : FU result handshake (fu_*) and CDB outputs (cdb_*)
module cdb_arbiter #(
    parameter int unsigned NUM_FU     = cpu_pkg::NUM_FU,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PREG_W     = cpu_pkg::PREG_W,
    parameter int unsigned XLEN       = cpu_pkg::XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] fifo_push;
    logic [NUM_FU-1:0] fifo_pop;
    logic [NUM_FU-1:0] fifo_full;
    logic [NUM_FU-1:0] fifo_empty;
    cpu_pkg::cdb_pkt_t push_pkt [NUM_FU];
    cpu_pkg::cdb_pkt_t head_pkt [NUM_FU];

    logic              cdb_valid_q, cdb_valid_d;
    logic [PREG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]   cdb_data_q, cdb_data_d;
    logic [1:0]        cdb_fu_id_q, cdb_fu_id_d;
    logic [IdxW-1:0]   last_q, last_d;

    logic              grant;
    logic              grant_found;
    logic [IdxW-1:0]   grant_idx;
    int unsigned       scan;

    // Ready comes from registered occupancy only; a same-cycle pop gives no credit.
    assign bus.fu_ready  = ~fifo_full;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_fu_id = cdb_fu_id_q;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign fifo_push[g]     = bus.fu_valid[g] & ~fifo_full[g] & ~flush;
        assign push_pkt[g].tag  = bus.fu_tag[g*PREG_W +: PREG_W];
        assign push_pkt[g].data = bus.fu_data[g*XLEN +: XLEN];

        cdb_fifo #(
            .DEPTH    (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .push     (fifo_push[g]),
            .pop      (fifo_pop[g]),
            .push_pkt (push_pkt[g]),
            .head     (head_pkt[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g])
        );
    end

    // Scan from last_q+1 upward with wrap; the first non-empty FIFO wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        for (int unsigned k = 1; k <= NUM_FU; k++) begin
            scan = (32'(last_q) + k) % NUM_FU;
            if (!grant_found && !fifo_empty[IdxW'(scan)]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(scan);
            end
        end
    end

    assign grant = grant_found & ~flush;

    always_comb begin
        fifo_pop = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            fifo_pop[i] = grant && (grant_idx == IdxW'(i));
        end
    end

    always_comb begin
        cdb_valid_d = grant;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_fu_id_d = cdb_fu_id_q;
        last_d      = last_q;
        if (grant) begin
            cdb_tag_d   = head_pkt[grant_idx].tag;
            cdb_data_d  = head_pkt[grant_idx].data;
            cdb_fu_id_d = 2'(grant_idx);
            last_d      = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_fu_id_q <= '0;
            // Start at the last FU so FU0 wins the first grant.
            last_q      <= IdxW'(NUM_FU - 1);
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_fu_id_q <= cdb_fu_id_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention order,
// backpressure/ordering, flush and asynchronous reset mid-stream.
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(3), .PREG_W(6), .XLEN(32)) bus ();

    cdb_arbiter #(
        .NUM_FU     (3),
        .FIFO_DEPTH (2),
        .PREG_W     (6),
        .XLEN       (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [5:0] t, input logic [31:0] d);
        bus.fu_valid[i]       = v;
        bus.fu_tag[i*6 +: 6]  = t;
        bus.fu_data[i*32 +: 32] = d;
    endtask

    task automatic idle();
        bus.fu_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [5:0]  nt [3];
    int          exp_t [3];
    logic [2:0]  acc;
    logic [2:0]  exp_rdy;
    int          id;
    int          drain_id [5];

    initial begin
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_data  = '0;

        // 1. Reset
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid", 64'(bus.cdb_valid), 64'd0);
            check("rst_tag", 64'(bus.cdb_tag), 64'd0);
            check("rst_data", 64'(bus.cdb_data), 64'd0);
            check("rst_ready", 64'(bus.fu_ready), 64'b111);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", 64'(bus.cdb_valid), 64'd0);
            check("idle_fuid", 64'(bus.cdb_fu_id), 64'd0);
            check("idle_ready", 64'(bus.fu_ready), 64'b111);
        end

        // 2. Single result from FU1
        set_fu(1, 1'b1, 6'd17, 32'hDEADBEEF);
        step();
        idle();
        check("single_nobypass", 64'(bus.cdb_valid), 64'd0);
        step();
        check("single_valid", 64'(bus.cdb_valid), 64'd1);
        check("single_tag", 64'(bus.cdb_tag), 64'd17);
        check("single_data", 64'(bus.cdb_data), 64'hDEADBEEF);
        check("single_fuid", 64'(bus.cdb_fu_id), 64'd1);
        step();
        check("single_once", 64'(bus.cdb_valid), 64'd0);
        check("single_hold_tag", 64'(bus.cdb_tag), 64'd17);

        // 3. Three-way contention from a fresh round-robin pointer
        do_reset();
        set_fu(0, 1'b1, 6'd5, 32'h0000_0105);
        set_fu(1, 1'b1, 6'd6, 32'h0000_0106);
        set_fu(2, 1'b1, 6'd7, 32'h0000_0107);
        step();
        idle();
        check("cont_lat", 64'(bus.cdb_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("cont_valid", 64'(bus.cdb_valid), 64'd1);
            check("cont_fuid", 64'(bus.cdb_fu_id), 64'(i));
            check("cont_tag", 64'(bus.cdb_tag), 64'(5 + i));
            check("cont_data", 64'(bus.cdb_data), 64'(32'h105 + i));
        end
        step();
        check("cont_4th", 64'(bus.cdb_valid), 64'd0);

        // 4. Backpressure: everyone pushes every cycle; last grant is FU2 here
        nt[0] = 6'd32; nt[1] = 6'd48; nt[2] = 6'd10;
        exp_t[0] = 32; exp_t[1] = 48; exp_t[2] = 10;
        for (int k = 1; k <= 12; k++) begin
            for (int i = 0; i < 3; i++) set_fu(i, 1'b1, nt[i], {26'h0, nt[i]} | (32'(i) << 16));
            acc = bus.fu_valid & bus.fu_ready;
            step();
            for (int i = 0; i < 3; i++) if (acc[i]) nt[i] = nt[i] + 6'd1;
            if (k == 1)          exp_rdy = 3'b111;
            else if (k % 3 == 2) exp_rdy = 3'b001;
            else if (k % 3 == 0) exp_rdy = 3'b010;
            else                 exp_rdy = 3'b100;
            check("bp_ready", 64'(bus.fu_ready), 64'(exp_rdy));
            if (k == 1) begin
                check("bp_first_valid", 64'(bus.cdb_valid), 64'd0);
            end else begin
                id = (k - 2) % 3;
                check("bp_valid", 64'(bus.cdb_valid), 64'd1);
                check("bp_fuid", 64'(bus.cdb_fu_id), 64'(id));
                check("bp_tag", 64'(bus.cdb_tag), 64'(exp_t[id]));
                check("bp_data", 64'(bus.cdb_data), 64'(exp_t[id]) | (64'(id) << 16));
                exp_t[id]++;
            end
        end
        idle();
        drain_id = '{2, 0, 1, 2, 0};
        for (int j = 0; j < 5; j++) begin
            step();
            id = drain_id[j];
            check("drain_valid", 64'(bus.cdb_valid), 64'd1);
            check("drain_fuid", 64'(bus.cdb_fu_id), 64'(id));
            check("drain_tag", 64'(bus.cdb_tag), 64'(exp_t[id]));
            exp_t[id]++;
        end
        step();
        check("drain_empty", 64'(bus.cdb_valid), 64'd0);
        check("bp_fu0_none_lost", 64'(exp_t[0]), 64'(nt[0]));
        check("bp_fu1_none_lost", 64'(exp_t[1]), 64'(nt[1]));
        check("bp_fu2_none_lost", 64'(exp_t[2]), 64'd15);

        // 5. Flush with results buffered in FU0/FU1 and an FU2 push in the flush cycle
        do_reset();
        set_fu(0, 1'b1, 6'd20, 32'h20);
        set_fu(1, 1'b1, 6'd21, 32'h21);
        step();
        check("fl_pre_valid", 64'(bus.cdb_valid), 64'd0);
        set_fu(0, 1'b1, 6'd22, 32'h22);
        set_fu(1, 1'b1, 6'd23, 32'h23);
        step();
        idle();
        set_fu(2, 1'b1, 6'd30, 32'h30);
        flush = 1'b1;
        check("fl_visible_valid", 64'(bus.cdb_valid), 64'd1);
        check("fl_visible_tag", 64'(bus.cdb_tag), 64'd20);
        check("fl_ready_full1", 64'(bus.fu_ready), 64'b101);
        step();
        flush = 1'b0;
        idle();
        check("fl_valid", 64'(bus.cdb_valid), 64'd0);
        check("fl_ready", 64'(bus.fu_ready), 64'b111);
        for (int i = 0; i < 4; i++) begin
            step();
            check("fl_nothing", 64'(bus.cdb_valid), 64'd0);
        end

        // 6. Async reset mid-stream; last grant is FU0 so FU1 goes first
        set_fu(0, 1'b1, 6'd40, 32'h40);
        set_fu(1, 1'b1, 6'd41, 32'h41);
        set_fu(2, 1'b1, 6'd42, 32'h42);
        step();
        idle();
        step();
        check("ar_valid", 64'(bus.cdb_valid), 64'd1);
        check("ar_tag", 64'(bus.cdb_tag), 64'd41);
        check("ar_fuid", 64'(bus.cdb_fu_id), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_async_valid", 64'(bus.cdb_valid), 64'd0);
        check("ar_async_tag", 64'(bus.cdb_tag), 64'd0);
        check("ar_async_data", 64'(bus.cdb_data), 64'd0);
        check("ar_async_fuid", 64'(bus.cdb_fu_id), 64'd0);
        check("ar_async_ready", 64'(bus.fu_ready), 64'b111);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ar_lost", 64'(bus.cdb_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
